// File: rtl/mem_arbiter.sv
// Two-requester scheduler for a 1W/1R synchronous memory macro: zero-fills the array
// after reset, then shares the write and read ports and steers read data back to its issuer.
module mem_arbiter #(
  parameter int DATA = 32,
  parameter int ADDR = 10
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            a_req,
  input  logic            a_we,
  input  logic [ADDR-1:0] a_addr,
  input  logic [DATA-1:0] a_wdata,
  output logic            a_gnt,
  output logic            a_rvalid,
  output logic [DATA-1:0] a_rdata,

  input  logic            b_req,
  input  logic            b_we,
  input  logic [ADDR-1:0] b_addr,
  input  logic [DATA-1:0] b_wdata,
  output logic            b_gnt,
  output logic            b_rvalid,
  output logic [DATA-1:0] b_rdata,

  output logic            mem_wr_en,
  output logic [ADDR-1:0] mem_wr_addr,
  output logic [DATA-1:0] mem_wr_data,
  output logic            mem_rd_en,
  output logic [ADDR-1:0] mem_rd_addr,
  input  logic [DATA-1:0] mem_rd_data,

  output logic            init_done
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_ARB  = 1'b1
  } state_t;

  localparam logic [ADDR-1:0] LAST_ADDR = {ADDR{1'b1}};
  localparam logic [ADDR-1:0] ADDR_ONE  = {{(ADDR-1){1'b0}}, 1'b1};
  localparam logic            ID_A      = 1'b0;
  localparam logic            ID_B      = 1'b1;

  state_t          state_q, state_d;
  logic [ADDR-1:0] cnt_q, cnt_d;
  logic            prio_q, prio_d;     // 0: A wins a tie, 1: B wins a tie
  logic            init_done_q, init_done_d;

  logic            wr_en_q, wr_en_d;
  logic [ADDR-1:0] wr_addr_q, wr_addr_d;
  logic [DATA-1:0] wr_data_q, wr_data_d;
  logic            rd_en_q, rd_en_d;
  logic [ADDR-1:0] rd_addr_q, rd_addr_d;

  // Read return pipeline: stage 1 rides alongside mem_rd_en, stage 2 aligns with mem_rd_data.
  logic            rd_id1_q, rd_id1_d;
  logic            rd_v2_q, rd_v2_d;
  logic            rd_id2_q, rd_id2_d;

  logic            a_rvalid_q, a_rvalid_d;
  logic [DATA-1:0] a_rdata_q, a_rdata_d;
  logic            b_rvalid_q, b_rvalid_d;
  logic [DATA-1:0] b_rdata_q, b_rdata_d;

  logic            a_wc_s, b_wc_s, a_rc_s, b_rc_s;
  logic            a_wg_s, b_wg_s, a_rg_s, b_rg_s;

  always_comb begin
    a_wc_s = a_req & a_we & init_done_q;
    b_wc_s = b_req & b_we & init_done_q;
    a_rc_s = a_req & ~a_we & init_done_q;
    b_rc_s = b_req & ~b_we & init_done_q;

    a_wg_s = a_wc_s & (~b_wc_s | ~prio_q);
    b_wg_s = b_wc_s & (~a_wc_s | prio_q);
    a_rg_s = a_rc_s & (~b_rc_s | ~prio_q);
    b_rg_s = b_rc_s & (~a_rc_s | prio_q);

    a_gnt = a_wg_s | a_rg_s;
    b_gnt = b_wg_s | b_rg_s;

    state_d     = state_q;
    cnt_d       = cnt_q;
    prio_d      = prio_q;
    init_done_d = (state_q == ST_ARB);
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    rd_en_d     = 1'b0;
    rd_addr_d   = rd_addr_q;
    rd_id1_d    = rd_id1_q;
    rd_v2_d     = rd_en_q;
    rd_id2_d    = rd_id1_q;

    case (state_q)
      ST_INIT: begin
        wr_en_d   = 1'b1;
        wr_addr_d = cnt_q;
        wr_data_d = {DATA{1'b0}};
        cnt_d     = cnt_q + ADDR_ONE;
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_ARB;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_ARB: begin
        if (a_wg_s) begin
          wr_en_d   = 1'b1;
          wr_addr_d = a_addr;
          wr_data_d = a_wdata;
        end else if (b_wg_s) begin
          wr_en_d   = 1'b1;
          wr_addr_d = b_addr;
          wr_data_d = b_wdata;
        end else begin
          wr_en_d   = 1'b0;
        end

        if (a_rg_s) begin
          rd_en_d   = 1'b1;
          rd_addr_d = a_addr;
          rd_id1_d  = ID_A;
        end else if (b_rg_s) begin
          rd_en_d   = 1'b1;
          rd_addr_d = b_addr;
          rd_id1_d  = ID_B;
        end else begin
          rd_en_d   = 1'b0;
        end

        // Priority moves to the loser, and only when a slot was actually contended.
        if ((a_wc_s & b_wc_s) | (a_rc_s & b_rc_s)) begin
          prio_d = ~prio_q;
        end else begin
          prio_d = prio_q;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = {ADDR{1'b0}};
      end
    endcase

    a_rvalid_d = rd_v2_q & (rd_id2_q == ID_A);
    b_rvalid_d = rd_v2_q & (rd_id2_q == ID_B);
    if (a_rvalid_d) begin
      a_rdata_d = mem_rd_data;
    end else begin
      a_rdata_d = a_rdata_q;
    end
    if (b_rvalid_d) begin
      b_rdata_d = mem_rd_data;
    end else begin
      b_rdata_d = b_rdata_q;
    end
  end

  // State, port registers and read-return pipeline; reset drops any reads still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      cnt_q       <= {ADDR{1'b0}};
      prio_q      <= 1'b0;
      init_done_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= {ADDR{1'b0}};
      wr_data_q   <= {DATA{1'b0}};
      rd_en_q     <= 1'b0;
      rd_addr_q   <= {ADDR{1'b0}};
      rd_id1_q    <= 1'b0;
      rd_v2_q     <= 1'b0;
      rd_id2_q    <= 1'b0;
      a_rvalid_q  <= 1'b0;
      a_rdata_q   <= {DATA{1'b0}};
      b_rvalid_q  <= 1'b0;
      b_rdata_q   <= {DATA{1'b0}};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prio_q      <= prio_d;
      init_done_q <= init_done_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      rd_id1_q    <= rd_id1_d;
      rd_v2_q     <= rd_v2_d;
      rd_id2_q    <= rd_id2_d;
      a_rvalid_q  <= a_rvalid_d;
      a_rdata_q   <= a_rdata_d;
      b_rvalid_q  <= b_rvalid_d;
      b_rdata_q   <= b_rdata_d;
    end
  end

  assign mem_wr_en   = wr_en_q;
  assign mem_wr_addr = wr_addr_q;
  assign mem_wr_data = wr_data_q;
  assign mem_rd_en   = rd_en_q;
  assign mem_rd_addr = rd_addr_q;
  assign a_rvalid    = a_rvalid_q;
  assign a_rdata     = a_rdata_q;
  assign b_rvalid    = b_rvalid_q;
  assign b_rdata     = b_rdata_q;
  assign init_done   = init_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 1W/1R memory (read-before-write).
module tb_mem_arbiter;

  localparam int DATA = 32;
  localparam int ADDR = 10;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            a_req = 1'b0, a_we = 1'b0;
  logic [ADDR-1:0] a_addr = '0;
  logic [DATA-1:0] a_wdata = '0;
  logic            a_gnt, a_rvalid;
  logic [DATA-1:0] a_rdata;
  logic            b_req = 1'b0, b_we = 1'b0;
  logic [ADDR-1:0] b_addr = '0;
  logic [DATA-1:0] b_wdata = '0;
  logic            b_gnt, b_rvalid;
  logic [DATA-1:0] b_rdata;
  logic            mem_wr_en, mem_rd_en, init_done;
  logic [ADDR-1:0] mem_wr_addr, mem_rd_addr;
  logic [DATA-1:0] mem_wr_data;
  logic [DATA-1:0] mem_rd_data;

  logic [DATA-1:0] mem [2**ADDR];

  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter #(.DATA(DATA), .ADDR(ADDR)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 2**ADDR; i++) mem[i] = 32'hA5A5_A5A5;
  end

  // Memory macro: registered read of the old contents, write at the same edge.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // One write-slot step: drive both requesters, check grants, then the issued write.
  task automatic wstep(input logic ar, input logic br, input logic ga, input logic gb,
                       input logic [ADDR-1:0] aa, input logic [ADDR-1:0] ba);
    a_req = ar; a_we = 1'b1; a_addr = aa; a_wdata = 32'hA000_0000 | 32'(aa);
    b_req = br; b_we = 1'b1; b_addr = ba; b_wdata = 32'hB000_0000 | 32'(ba);
    #1;
    chk1("ws_a_gnt", a_gnt, ga);
    chk1("ws_b_gnt", b_gnt, gb);
    tick();
    chk1("ws_wr_en", mem_wr_en, 1'b1);
    chk32("ws_wr_addr", 32'(mem_wr_addr), ga ? 32'(aa) : 32'(ba));
    chk32("ws_wr_data", mem_wr_data, ga ? (32'hA000_0000 | 32'(aa)) : (32'hB000_0000 | 32'(ba)));
  endtask

  initial begin
    int wr_cnt, first_cyc, last_cyc, done_cyc, addr_err, data_err, gnt_err, drop_err, j;
    wr_cnt = 0; first_cyc = 0; last_cyc = 0; done_cyc = 0;
    addr_err = 0; data_err = 0; gnt_err = 0; drop_err = 0;

    // Reset state
    repeat (3) tick();
    chk1("rst_wr_en", mem_wr_en, 1'b0);
    chk1("rst_rd_en", mem_rd_en, 1'b0);
    chk1("rst_init_done", init_done, 1'b0);
    chk1("rst_a_rvalid", a_rvalid, 1'b0);
    chk1("rst_b_rvalid", b_rvalid, 1'b0);
    chk32("rst_wr_addr", 32'(mem_wr_addr), 32'd0);
    chk32("rst_rd_addr", 32'(mem_rd_addr), 32'd0);
    chk32("rst_wr_data", mem_wr_data, 32'd0);
    chk32("rst_a_rdata", a_rdata, 32'd0);
    chk32("rst_b_rdata", b_rdata, 32'd0);

    // Array clear: requests held high must not be granted until init_done
    a_req = 1'b1; a_we = 1'b1; b_req = 1'b1; b_we = 1'b0;
    rst = 1'b0;
    for (int cyc = 1; cyc <= 1030; cyc++) begin
      tick();
      if (mem_wr_en) begin
        if (wr_cnt == 0) first_cyc = cyc;
        if (mem_wr_addr !== 10'(wr_cnt)) addr_err++;
        if (mem_wr_data !== 32'd0) data_err++;
        wr_cnt++;
        last_cyc = cyc;
      end
      if (!init_done && (a_gnt || b_gnt)) gnt_err++;
      if (done_cyc != 0 && !init_done) drop_err++;
      if (init_done && done_cyc == 0) begin
        done_cyc = cyc;
        chk1("arb_first_a_gnt", a_gnt, 1'b1);
        chk1("arb_first_b_gnt", b_gnt, 1'b1);
        a_req = 1'b0; b_req = 1'b0;
      end
    end
    chk32("init_first_cyc", first_cyc, 32'd1);
    chk32("init_wr_count", wr_cnt, 32'd1024);
    chk32("init_last_cyc", last_cyc, 32'd1024);
    chk32("init_done_cyc", done_cyc, 32'd1025);
    chk32("init_addr_err", addr_err, 32'd0);
    chk32("init_data_err", data_err, 32'd0);
    chk32("init_gnt_err", gnt_err, 32'd0);
    chk32("init_done_drop", drop_err, 32'd0);
    chk32("init_mem0", mem[0], 32'd0);
    chk32("init_mem512", mem[512], 32'd0);
    chk32("init_mem1023", mem[1023], 32'd0);

    // A writes DEADBEEF@5, then reads it back
    a_req = 1'b1; a_we = 1'b1; a_addr = 10'd5; a_wdata = 32'hDEAD_BEEF;
    #1 chk1("w5_a_gnt", a_gnt, 1'b1);
    tick();
    chk1("w5_wr_en", mem_wr_en, 1'b1);
    chk32("w5_wr_addr", 32'(mem_wr_addr), 32'd5);
    chk32("w5_wr_data", mem_wr_data, 32'hDEAD_BEEF);
    a_we = 1'b0;
    #1 chk1("r5_a_gnt", a_gnt, 1'b1);
    tick();
    a_req = 1'b0;
    chk1("r5_rd_en", mem_rd_en, 1'b1);
    chk32("r5_rd_addr", 32'(mem_rd_addr), 32'd5);
    chk1("r5_wr_idle", mem_wr_en, 1'b0);
    tick();
    chk1("r5_rvalid_early", a_rvalid, 1'b0);
    tick();
    chk1("r5_a_rvalid", a_rvalid, 1'b1);
    chk32("r5_a_rdata", a_rdata, 32'hDEAD_BEEF);
    chk1("r5_b_rvalid", b_rvalid, 1'b0);
    tick();
    chk1("r5_rvalid_pulse", a_rvalid, 1'b0);
    chk32("r5_rdata_hold", a_rdata, 32'hDEAD_BEEF);

    // Preload @1 and @2 one at a time (no contention), then both read every cycle
    a_req = 1'b1; a_we = 1'b1; a_addr = 10'd1; a_wdata = 32'h1111_0001;
    tick();
    a_req = 1'b0;
    b_req = 1'b1; b_we = 1'b1; b_addr = 10'd2; b_wdata = 32'h2222_0002;
    tick();
    b_req = 1'b0;
    for (int i = 0; i < 9; i++) begin
      a_req = (i < 6); a_we = 1'b0; a_addr = 10'd1;
      b_req = (i < 6); b_we = 1'b0; b_addr = 10'd2;
      #1;
      if (i < 6) begin
        chk1("rr_a_gnt", a_gnt, (i % 2) == 0);
        chk1("rr_b_gnt", b_gnt, (i % 2) == 1);
      end
      tick();
      chk1("rr_rd_en", mem_rd_en, i < 6);
      if (i >= 2) begin
        j = i - 2;
        chk1("rr_a_rvalid", a_rvalid, (j < 6) && ((j % 2) == 0));
        chk1("rr_b_rvalid", b_rvalid, (j < 6) && ((j % 2) == 1));
        chk32("rr_a_rdata", a_rdata, 32'h1111_0001);
        if (i >= 3) chk32("rr_b_rdata", b_rdata, 32'h2222_0002);
      end
    end
    a_req = 1'b0; b_req = 1'b0;

    // Same-cycle write@7 by A and read@7 by B: old data, then new data on reread
    a_req = 1'b1; a_we = 1'b1; a_addr = 10'd7; a_wdata = 32'h0000_0011;
    b_req = 1'b1; b_we = 1'b0; b_addr = 10'd7;
    #1;
    chk1("h7_a_gnt", a_gnt, 1'b1);
    chk1("h7_b_gnt", b_gnt, 1'b1);
    tick();
    a_req = 1'b0;
    chk1("h7_wr_en", mem_wr_en, 1'b1);
    chk1("h7_rd_en", mem_rd_en, 1'b1);
    chk32("h7_rd_addr", 32'(mem_rd_addr), 32'd7);
    #1 chk1("h7_reread_gnt", b_gnt, 1'b1);
    tick();
    b_req = 1'b0;
    chk1("h7_rvalid_early", b_rvalid, 1'b0);
    tick();
    chk1("h7_old_rvalid", b_rvalid, 1'b1);
    chk32("h7_old_rdata", b_rdata, 32'd0);
    tick();
    chk1("h7_new_rvalid", b_rvalid, 1'b1);
    chk32("h7_new_rdata", b_rdata, 32'h0000_0011);
    tick();
    chk1("h7_rvalid_end", b_rvalid, 1'b0);
    chk1("h7_a_rvalid", a_rvalid, 1'b0);

    // Write contention; prio is A here (six read ties). Loser retries its held address.
    wstep(1'b1, 1'b1, 1'b1, 1'b0, 10'h40, 10'h50);
    wstep(1'b1, 1'b1, 1'b0, 1'b1, 10'h41, 10'h50);
    wstep(1'b1, 1'b1, 1'b1, 1'b0, 10'h41, 10'h51);
    wstep(1'b0, 1'b1, 1'b0, 1'b1, 10'h42, 10'h51);
    wstep(1'b1, 1'b1, 1'b0, 1'b1, 10'h42, 10'h52);
    wstep(1'b1, 1'b1, 1'b1, 1'b0, 10'h42, 10'h53);
    a_req = 1'b0; b_req = 1'b0;
    tick();
    chk1("idle_wr_en", mem_wr_en, 1'b0);
    chk1("idle_rd_en", mem_rd_en, 1'b0);
    chk32("idle_wr_addr_hold", 32'(mem_wr_addr), 32'h42);
    chk32("idle_wr_data_hold", mem_wr_data, 32'hA000_0042);

    // Reset with two reads in flight: no rvalid, INIT restarts at address 0
    a_req = 1'b1; a_we = 1'b0; a_addr = 10'd1;
    #1 chk1("rf_a_gnt", a_gnt, 1'b1);
    tick();
    a_req = 1'b0;
    b_req = 1'b1; b_we = 1'b0; b_addr = 10'd2;
    #1 chk1("rf_b_gnt", b_gnt, 1'b1);
    tick();
    b_req = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk1("rf_a_rvalid", a_rvalid, 1'b0);
      chk1("rf_b_rvalid", b_rvalid, 1'b0);
      chk1("rf_init_done", init_done, 1'b0);
      chk1("rf_wr_en", mem_wr_en, 1'b0);
      chk1("rf_rd_en", mem_rd_en, 1'b0);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk1("rs_a_rvalid", a_rvalid, 1'b0);
      chk1("rs_b_rvalid", b_rvalid, 1'b0);
      chk1("rs_init_done", init_done, 1'b0);
      chk1("rs_wr_en", mem_wr_en, 1'b1);
      chk32("rs_wr_addr", 32'(mem_wr_addr), 32'(i));
      chk32("rs_wr_data", mem_wr_data, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
